// File: rtl/mant_div_pkg.sv
// rtl/mant_div_pkg.sv - shared types and widths for the mantissa divider
package mant_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } div_state_t;

  // FPU mantissa width; default operand width of the divider
  localparam int MANT_W = 58;

endpackage

// File: rtl/mant_div_seq_if.sv
// rtl/mant_div_seq_if.sv - operand/result handshake bundle for the mantissa divider
interface mant_div_seq_if
  import mant_div_pkg::*;
#(
  parameter int W = MANT_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         sticky;
  logic         dbz;

  // requester side: supplies operands, consumes results
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, quo, rem, sticky, dbz
  );

  // divider side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, quo, rem, sticky, dbz
  );

endinterface

// File: rtl/mant_div_step.sv
// rtl/mant_div_step.sv - one combinational restoring-division step
module mant_div_step #(
  parameter int W = 58
) (
  input  logic [W-1:0] prem,
  input  logic         din,
  input  logic [W-1:0] bd,
  output logic [W-1:0] prem_nxt,
  output logic         qbit
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // Shift in the next dividend bit and try subtracting the divisor; a clear
  // sign bit means the divisor fit, so keep the difference and emit a 1.
  always_comb begin
    shifted  = {prem, din};
    trial    = shifted - {1'b0, bd};
    qbit     = ~trial[W];
    prem_nxt = trial[W] ? shifted[W-1:0] : trial[W-1:0];
  end

endmodule

// File: rtl/mant_div_seq.sv
// rtl/mant_div_seq.sv - iterative radix-2 restoring divider, one quotient bit per cycle
module mant_div_seq
  import mant_div_pkg::*;
#(
  parameter int W = MANT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  mant_div_seq_if.slave  bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  qsr;
  // Restoring keeps the partial remainder below the divisor, so its top
  // (W-th) bit is always zero and only the low W bits are stored.
  logic [W-1:0]  prem;
  logic [W-1:0]  bd;

  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic          sticky_q;
  logic          dbz_q;

  logic [W-1:0]  step_prem;
  logic          step_q;

  mant_div_step #(.W(W)) u_step (
    .prem     (prem),
    .din      (qsr[W-1]),
    .bd       (bd),
    .prem_nxt (step_prem),
    .qbit     (step_q)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quo       = quo_q;
  assign bus.rem       = rem_q;
  assign bus.sticky    = sticky_q;
  assign bus.dbz       = dbz_q;

  // Control FSM plus datapath registers; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      qsr         <= '0;
      prem        <= '0;
      bd          <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      sticky_q    <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            qsr        <= bus.a;
            bd         <= bus.b;
            prem       <= '0;
            cnt        <= CNT_INIT;
            dbz_q      <= (bus.b == '0);
            in_ready_q <= 1'b0;
            state      <= (bus.b == '0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          prem <= step_prem;
          qsr  <= {qsr[W-2:0], step_q};
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            quo_q       <= {qsr[W-2:0], step_q};
            rem_q       <= step_prem;
            sticky_q    <= |step_prem;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            // Divide-by-zero arrives here straight from IDLE; qsr still holds a.
            out_valid_q <= 1'b1;
            quo_q       <= '1;
            rem_q       <= qsr;
            sticky_q    <= |qsr;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mant_div_seq.sv
// tb/tb_mant_div_seq.sv - self-checking bench for the mantissa divider
module tb_mant_div_seq;
  import mant_div_pkg::*;

  localparam int W = MANT_W;
  localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   cyc;

  mant_div_seq_if #(.W(W)) dif ();

  mant_div_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Reference: plain integer division; b == 0 yields all-ones quotient, rem = a.
  function automatic void ref_div(input logic [63:0] av, input logic [63:0] bv,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output logic s, output logic z);
    if (bv == 64'd0) begin
      q = MASK;
      r = av;
      z = 1'b1;
    end else begin
      q = av / bv;
      r = av % bv;
      z = 1'b0;
    end
    s = (r != 64'd0);
  endfunction

  function automatic logic [63:0] rand58();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v & MASK;
  endfunction

  // Presents one operand pair, scrambles the inputs after accept, and waits for out_valid.
  task automatic run_op(input logic [63:0] av, input logic [63:0] bv,
                        output logic [63:0] q, output logic [63:0] r,
                        output logic s, output logic z, output int lat);
    int k;
    q = 64'd0; r = 64'd0; s = 1'b0; z = 1'b0; lat = -1;
    k = 0;
    while (!dif.in_ready && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (!dif.in_ready) return;
    dif.in_valid = 1'b1;
    dif.a = av[W-1:0];
    dif.b = bv[W-1:0];
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    dif.a = rand58();
    dif.b = rand58();
    k = 0;
    while (!dif.out_valid && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (!dif.out_valid) return;
    lat = k;
    q = 64'(dif.quo);
    r = 64'(dif.rem);
    s = dif.sticky;
    z = dif.dbz;
  endtask

  task automatic drain(output logic ok);
    dif.out_ready = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    ok = dif.in_ready && !dif.out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dif.in_valid = 1'b0; dif.out_ready = 1'b0; dif.a = '0; dif.b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 0 0", dif.in_ready, dif.out_valid);
    end
    n_cmp++;
    if (dif.quo !== '0 || dif.rem !== '0 || dif.sticky !== 1'b0 || dif.dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_res: quo=%h rem=%h sticky=%b dbz=%b required all 0", dif.quo, dif.rem, dif.sticky, dif.dbz);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", dif.in_ready, dif.out_valid);
    end
  endtask

  task automatic check_op(input string name, input logic [63:0] av, input logic [63:0] bv);
    logic [63:0]  q, r, eq, er;
    logic         s, z, es, ez, ok;
    logic [127:0] prod;
    int           lat, elat;
    run_op(av, bv, q, r, s, z, lat);
    ref_div(av, bv, eq, er, es, ez);
    elat = ez ? 1 : W;
    n_cmp++;
    if (lat !== elat) begin
      n_fail++;
      $display("FAIL %s_lat: got %0d required %0d", name, lat, elat);
    end
    n_cmp++;
    if (q !== eq || r !== er || s !== es || z !== ez) begin
      n_fail++;
      $display("FAIL %s_res: a=%h b=%h got q=%h r=%h s=%b z=%b required q=%h r=%h s=%b z=%b",
               name, av, bv, q, r, s, z, eq, er, es, ez);
    end
    if (!ez) begin
      prod = 128'(q) * 128'(bv) + 128'(r);
      n_cmp++;
      if (prod !== 128'(av)) begin
        n_fail++;
        $display("FAIL %s_ident: q*b+r=%h required %h", name, prod, av);
      end
    end
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_drain: in_ready=%b out_valid=%b required 1 0", name, dif.in_ready, dif.out_valid);
    end
  endtask

  task automatic test_directed();
    check_op("d144_12", 64'd144, 64'd12);
    check_op("d2_1", 64'd2, 64'd1);
    check_op("d1_2", 64'd1, 64'd2);
    check_op("dmax_1", MASK, 64'd1);
    check_op("dalt", 64'h0155_5555_5555_5555, 64'h0333_3333_3333_3333);
    check_op("dbz12", 64'd12, 64'd0);
    check_op("dbz0", 64'd0, 64'd0);
    check_op("dmax_max", MASK, MASK);
  endtask

  task automatic test_hold();
    logic [63:0] q, r;
    logic        s, z, ok;
    int          lat;
    logic        bad;
    run_op(64'd1000, 64'd7, q, r, s, z, lat);
    n_cmp++;
    if (lat !== W || q !== 64'd142 || r !== 64'd6) begin
      n_fail++;
      $display("FAIL hold_res: lat=%0d q=%0d r=%0d required %0d 142 6", lat, q, r, W);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0 || 64'(dif.quo) !== q ||
          64'(dif.rem) !== r || dif.sticky !== s || dif.dbz !== z)
        bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_stable: outputs changed got bad=%b required 0", bad);
    end
    drain(ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_drain: in_ready=%b out_valid=%b required 1 0", dif.in_ready, dif.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    while (!dif.in_ready) begin @(posedge clk); #1; end
    dif.in_valid = 1'b1; dif.a = 58'd144; dif.b = 58'd12;
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dif.in_ready !== 1'b0 || dif.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_inreset: in_ready=%b out_valid=%b required 0 0", dif.in_ready, dif.out_valid);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (dif.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_ready: in_ready=%b required 1", dif.in_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < W + 10; i++) begin
      @(posedge clk); #1;
      if (dif.out_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_novalid: out_valid seen=%b required 0", seen);
    end
    check_op("rmid_after", 64'd144, 64'd12);
  endtask

  task automatic test_random();
    logic [63:0] av, bv;
    for (int i = 0; i < 24; i++) begin
      av = rand58();
      bv = rand58() >> $urandom_range(0, 57);
      if ($urandom_range(0, 7) == 0) bv = 64'd0;
      if ($urandom_range(0, 5) == 0) av = av >> $urandom_range(30, 57);
      check_op("rnd", av, bv);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] av, bv, eq, er;
    logic        es, ez;
    int          acc_prev, acc_now, k;
    acc_prev = -1;
    dif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      av = rand58();
      bv = (rand58() >> $urandom_range(0, 50)) | 64'd1;
      ref_div(av, bv, eq, er, es, ez);
      k = 0;
      while (!dif.in_ready && k < 100) begin @(posedge clk); #1; k++; end
      dif.in_valid = 1'b1; dif.a = av[W-1:0]; dif.b = bv[W-1:0];
      @(posedge clk);
      acc_now = cyc;
      #1;
      dif.in_valid = 1'b0;
      if (acc_prev >= 0) begin
        n_cmp++;
        if (acc_now - acc_prev !== W + 2) begin
          n_fail++;
          $display("FAIL b2b_period: got %0d required %0d", acc_now - acc_prev, W + 2);
        end
      end
      acc_prev = acc_now;
      k = 0;
      while (!dif.out_valid && k < 200) begin @(posedge clk); #1; k++; end
      n_cmp++;
      if (dif.out_valid !== 1'b1 || 64'(dif.quo) !== eq || 64'(dif.rem) !== er || dif.sticky !== es) begin
        n_fail++;
        $display("FAIL b2b_res: valid=%b q=%h r=%h s=%b required 1 %h %h %b",
                 dif.out_valid, dif.quo, dif.rem, dif.sticky, eq, er, es);
      end
    end
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
